// File: rtl/score_scheduler_pkg.sv
// score_pkg: shared BCD digit type, scheduler FSM states and BCD helpers
package score_pkg;
    typedef logic [3:0] bcd_digit_t;
    typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;
    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
    endfunction
endpackage

// File: rtl/score_scheduler_if.sv
// score_if: requester/score bundle between the point sources and score_scheduler
// Signals: clear (new game), req/pts (per-requester add request + BCD points),
//          ack (grant pulse), score (committed BCD), busy, overflow (sticky)
interface score_if #(parameter int NUM = 4, parameter int DIGITS = 4);
    logic                         clear;
    logic [NUM-1:0]               req;
    logic [NUM-1:0][DIGITS-1:0][3:0] pts;
    logic [NUM-1:0]               ack;
    logic [DIGITS-1:0][3:0]       score;
    logic                         busy;
    logic                         overflow;
    modport master (output clear, req, pts, input ack, score, busy, overflow);
    modport slave  (input clear, req, pts, output ack, score, busy, overflow);
endinterface

// File: rtl/score_scheduler_bcd_digit_add.sv
// bcd_digit_add: single-digit BCD adder with decimal carry in/out
// Ports: a, b (BCD digits), cin -> s (BCD digit), cout (decimal carry)
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);
    logic [4:0] w_sum;
    assign w_sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign cout  = w_sum > 5'd9;
    // Adding 6 modulo 16 is the same as subtracting 10 on the low nibble
    assign s     = cout ? w_sum[3:0] + 4'd6 : w_sum[3:0];
endmodule

// File: rtl/score_scheduler.sv
// score_scheduler: round-robin arbiter feeding a digit-serial BCD score accumulator
// Ports: clk, resetN (async active-low), bus (score_if.slave: clear, req, pts,
//        ack, score, busy, overflow)
// Option: define SCORE_SAT_EN to saturate the score at all nines instead of wrapping
module score_scheduler
    import score_pkg::*;
#(
    parameter int NUM    = 4,
    parameter int DIGITS = 4
) (
    input logic   clk,
    input logic   resetN,
    score_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;
`ifdef SCORE_SAT_EN
    localparam logic [DIGITS-1:0][3:0] NINES = {DIGITS{4'h9}};
`endif
    state_t                 r_state, w_next;
    logic [DIGITS-1:0][3:0] r_work, r_op, r_score;
    logic                   r_carry, r_ovf;
    logic [IW-1:0]          r_idx;
    logic [PW-1:0]          r_rr, w_gidx, w_cand;
    logic                   w_found, w_grant, w_last;
    bcd_digit_t             w_s;
    logic                   w_cout;
    bcd_digit_add u_add (
        .a   (r_work[r_idx]),
        .b   (r_op[r_idx]),
        .cin (r_carry),
        .s   (w_s),
        .cout(w_cout)
    );
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        // Round-robin search starting at r_rr, wrapping at NUM
        for (int i = 0; i < NUM; i++) begin
            w_cand = PW'((int'(r_rr) + i) % NUM);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
        // resetN gates the grant so ack stays low throughout reset
        w_grant = resetN && (r_state == IDLE) && !bus.clear && w_found;
        w_last  = r_idx == IW'(DIGITS - 1);
        w_next  = bus.clear ? IDLE :
                  (r_state == IDLE) ? (w_grant ? ADD : IDLE) :
                  (r_state == ADD)  ? (w_last ? COMMIT : ADD) : IDLE;
    end
    assign bus.ack      = w_grant ? (NUM'(1) << w_gidx) : '0;
    assign bus.busy     = r_state != IDLE;
    assign bus.score    = r_score;
    assign bus.overflow = r_ovf;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_work  <= '0;
            r_op    <= '0;
            r_score <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_rr    <= '0;
        end else if (bus.clear) begin
            r_work  <= '0;
            r_op    <= '0;
            r_score <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_rr    <= '0;
        end else if (w_grant) begin
            for (int d = 0; d < DIGITS; d++) r_op[d] <= bcd_clamp(bus.pts[w_gidx][d]);
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_rr    <= (w_gidx == PW'(NUM - 1)) ? '0 : w_gidx + 1'b1;
        end else if (r_state == ADD) begin
            r_work[r_idx] <= w_s;
            r_carry       <= w_cout;
            r_idx         <= r_idx + 1'b1;
        end else if (r_state == COMMIT) begin
            r_ovf <= r_ovf | r_carry;
`ifdef SCORE_SAT_EN
            // Work is pinned at nines too, so later adds keep saturating
            r_score <= r_carry ? NINES : r_work;
            if (r_carry) r_work <= NINES;
`else
            r_score <= r_work;
`endif
        end
    end
endmodule

// File: doc/score_scheduler.md
SCORE_SCHEDULER -- requirements
Module: score_scheduler

Interface
REQ-001 The block SHALL have parameter NUM, default 4, giving the number of point requesters (1..8).
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the BCD digits of the score.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous new-game clear.
REQ-006 The block SHALL have port req, input, [NUM-1:0]: per-requester add request, level, held until ack.
REQ-007 The block SHALL have port pts, input, [NUM-1:0][DIGITS-1:0][3:0]: per-requester BCD points, stable while req is high.
REQ-008 The block SHALL have port ack, output, [NUM-1:0]: one-cycle grant/capture pulse, at most one bit high.
REQ-009 The block SHALL have port score, output, [DIGITS-1:0][3:0]: committed BCD score.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky; set when an add carries out of the top digit.

Function
REQ-012 The FSM SHALL have states IDLE, ADD and COMMIT.
REQ-013 In IDLE with any req set and clear low, the block SHALL grant one requester round-robin, searching upward from rr_ptr with wrap, pulse its ack, capture its pts into an operand register, zero the carry, zero the digit index, and go to ADD.
REQ-014 After a grant to requester k, rr_ptr SHALL become (k+1) mod NUM.
REQ-015 ADD SHALL process one digit per cycle, LSD first: work[i] = digit(work[i] + op[i] + carry), carry = decimal carry out, i increments; after digit DIGITS-1 it SHALL go to COMMIT.
REQ-016 COMMIT SHALL copy work to score, OR the final carry into overflow, and return to IDLE; no new grant SHALL occur in COMMIT.
REQ-017 score SHALL change only in COMMIT; partial sums SHALL never be visible.
REQ-018 Latency SHALL be: ack in cycle T, new score visible in cycle T+DIGITS+2; one add occupies DIGITS+2 cycles.
REQ-019 Any pts digit greater than 9 SHALL be clamped to 9 at capture.
REQ-020 Without saturation (see Configuration), the score SHALL wrap modulo 10^DIGITS on carry-out.
REQ-021 Requests arriving while busy SHALL wait; none SHALL be dropped while req stays high.
REQ-022 clear SHALL have priority over everything else: score, work and overflow go to 0, rr_ptr goes to 0, FSM goes to IDLE, and no ack is issued that cycle.
REQ-023 An add aborted by clear mid-ADD (already acked) SHALL be discarded.

Reset
REQ-024 While resetN is low: state=IDLE, score=0, work=0, operand=0, carry=0, rr_ptr=0, ack=0, busy=0, overflow=0.
REQ-025 On resetN deassertion, the first grant SHALL be possible on the first rising edge.

Configuration
REQ-026 With SCORE_SAT_EN defined, COMMIT with final carry SHALL load score with all nines (e.g. 9999) and set overflow; further adds SHALL keep all nines.
REQ-027 Without SCORE_SAT_EN, the wrap behaviour of REQ-020 SHALL apply, and overflow SHALL still be set.

Structure
REQ-028 A shared package score_pkg SHALL hold typedef bcd_digit_t (logic [3:0]), the FSM state enum, and constant BCD_MAX_DIGIT = 9.
REQ-029 A combinational sub-module bcd_digit_add SHALL be instantiated once (inputs a, b, cin; outputs s, cout) and time-shared across digits.

Verification
REQ-030 The bench SHALL check: reset, then req[0] with pts=0x0025 -> ack[0] one cycle, score=0x0025 at T+6, busy high 5 cycles (DIGITS=4).
REQ-031 The bench SHALL check: score 0x0995 plus pts 0x0005 -> score 0x1000 and overflow=0 (carry ripple across 3 digits).
REQ-032 The bench SHALL check: req=4'b1111 held -> acks in order 0,1,2,3,0 with 6-cycle spacing; all four adds sum correctly.
REQ-033 The bench SHALL check: score 0x9990 plus pts 0x0020 -> 0x0010 with overflow=1 without SCORE_SAT_EN, and 0x9999 with overflow=1 with it.
REQ-034 The bench SHALL check: clear asserted during ADD -> next cycle score=0, busy=0, overflow=0, and the acked add is lost.
REQ-035 The bench SHALL check: pts digit 0xC -> added as 9; resetN pulsed low mid-ADD -> immediate reset values.
